// File: rtl/task_2_pkg.sv
// Shared types and default timing for the task_2 WS2812 strip controller.
package task_2_pkg;

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_e;

  localparam logic [1:0] GREEN = 2'd0;
  localparam logic [1:0] RED   = 2'd1;
  localparam logic [1:0] BLUE  = 2'd2;

  localparam int unsigned DEF_NUM_PIXELS = 5;
  localparam int unsigned DEF_T0H_CYC    = 18;
  localparam int unsigned DEF_T1H_CYC    = 35;
  localparam int unsigned DEF_BIT_CYC    = 63;
  localparam int unsigned DEF_LATCH_CYC  = 2500;

endpackage

// File: rtl/task_2_neo_bit_tx.sv
// One WS2812 bit slot: high for T1H/T0H cycles, low for the rest of BIT_CYC.
module neo_bit_tx
  import task_2_pkg::*;
#(
  parameter int unsigned T0H_CYC = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC = DEF_T1H_CYC,
  parameter int unsigned BIT_CYC = DEF_BIT_CYC
) (
  input  logic clock,
  input  logic reset,
  input  logic i_start,
  input  logic i_bit,
  output logic o_data,
  output logic o_done
);

  localparam int unsigned CntW = $clog2(BIT_CYC);

  logic [CntW-1:0] r_cnt;
  logic            r_busy;
  logic            r_data;
  logic            w_last;
  int unsigned     w_high;

  // i_bit must stay stable for the whole slot; it is only consulted after the start edge.
  assign w_high = i_bit ? T1H_CYC : T0H_CYC;
  assign w_last = r_busy && (32'(r_cnt) == BIT_CYC - 32'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_data <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_data <= 1'b1;
    end else if (r_busy) begin
      if (w_last) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
        r_data <= 1'b0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_data <= (32'(r_cnt) + 32'd1) < w_high;
      end
    end
  end

  assign o_data = r_data;
  assign o_done = w_last;

endmodule

// File: rtl/task_2.sv
// WS2812 controller for a pixel chain: G/R/B register file, frame serialiser and latch gap.
// Define TASK2_AUTO_CLEAR_EN to clear all colour registers when the latch gap ends.
module task_2
  import task_2_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int unsigned T0H_CYC    = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC    = DEF_T1H_CYC,
  parameter int unsigned BIT_CYC    = DEF_BIT_CYC,
  parameter int unsigned LATCH_CYC  = DEF_LATCH_CYC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] pixel_index,
  input  logic [1:0] color_index,
  input  logic [7:0] color_level,
  input  logic       load_color,
  input  logic       send_it,
  output logic       neo_data,
  output logic       ready_to_load,
  output logic       ready_to_send
);

  localparam int unsigned NumEnt = NUM_PIXELS * 3;
  localparam int unsigned EntW   = $clog2(NumEnt);
  localparam int unsigned LatW   = $clog2(LATCH_CYC);

  state_e currstate, nextstate;

  logic [7:0]      r_regs [NumEnt];
  logic [2:0]      r_pix;
  logic [1:0]      r_col;
  logic [2:0]      r_bit_cnt;
  logic [LatW-1:0] r_latch_cnt;

  logic            w_load_ok;
  logic            w_accept;
  logic            w_last_bit;
  logic            w_bit_done;
  logic            w_start;
  logic            w_latch_done;
  logic [EntW-1:0] w_wr_sel;
  logic [EntW-1:0] w_rd_sel;
  logic [7:0]      w_rd_byte;
  logic            w_tx_bit;

  assign w_load_ok = (currstate == IDLE) && load_color &&
                     (32'(pixel_index) < NUM_PIXELS) && (color_index != 2'd3);
  assign w_wr_sel  = EntW'(32'(pixel_index) * 32'd3 + 32'(color_index));
  assign w_rd_sel  = EntW'(32'(r_pix) * 32'd3 + 32'(r_col));
  assign w_rd_byte = r_regs[w_rd_sel];
  assign w_tx_bit  = w_rd_byte[3'd7 - r_bit_cnt];

  assign w_accept     = (currstate == IDLE) && send_it;
  assign w_last_bit   = (32'(r_pix) == NUM_PIXELS - 32'd1) && (r_col == BLUE) && (r_bit_cnt == 3'd7);
  assign w_latch_done = (currstate == LATCH) && (32'(r_latch_cnt) == LATCH_CYC - 32'd1);
  // Back-to-back bit slots: restart the bit engine on the same edge the previous slot ends.
  assign w_start      = w_accept || ((currstate == SEND) && w_bit_done && !w_last_bit);

  neo_bit_tx #(
    .T0H_CYC(T0H_CYC),
    .T1H_CYC(T1H_CYC),
    .BIT_CYC(BIT_CYC)
  ) u_bit_tx (
    .clock  (clock),
    .reset  (reset),
    .i_start(w_start),
    .i_bit  (w_tx_bit),
    .o_data (neo_data),
    .o_done (w_bit_done)
  );

  always_comb begin
    nextstate = currstate;
    unique case (currstate)
      IDLE:    if (send_it) nextstate = SEND;
      SEND:    if (w_bit_done && w_last_bit) nextstate = LATCH;
      LATCH:   if (w_latch_done) nextstate = IDLE;
      default: nextstate = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      currstate   <= IDLE;
      r_pix       <= '0;
      r_col       <= GREEN;
      r_bit_cnt   <= '0;
      r_latch_cnt <= '0;
    end else begin
      currstate <= nextstate;
      if (w_accept || (w_bit_done && w_last_bit)) begin
        r_pix     <= '0;
        r_col     <= GREEN;
        r_bit_cnt <= '0;
      end else if ((currstate == SEND) && w_bit_done) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (r_bit_cnt == 3'd7) begin
          if (r_col == BLUE) begin
            r_col <= GREEN;
            r_pix <= r_pix + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
      end
      if ((currstate == LATCH) && !w_latch_done) r_latch_cnt <= r_latch_cnt + 1'b1;
      else                                       r_latch_cnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NumEnt; i++) r_regs[i] <= '0;
    end else if (w_load_ok) begin
      r_regs[w_wr_sel] <= color_level;
`ifdef TASK2_AUTO_CLEAR_EN
    end else if (w_latch_done) begin
      for (int unsigned i = 0; i < NumEnt; i++) r_regs[i] <= '0;
`endif
    end
  end

  assign ready_to_load = (currstate == IDLE);
  assign ready_to_send = (currstate == IDLE);

endmodule

// File: tb/tb_task_2.sv
// Bench for task_2: frame-level model checked every cycle, plus directed pulse-width checks.
module tb_task_2;

  localparam int BIT_C   = 63;
  localparam int T0      = 18;
  localparam int T1      = 35;
  localparam int NBITS   = 120;
  localparam int SEND_C  = NBITS * BIT_C;
  localparam int FRAME_C = SEND_C + 2500;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] pixel_index = '0;
  logic [1:0] color_index = '0;
  logic [7:0] color_level = '0;
  logic       load_color = 1'b0;
  logic       send_it = 1'b0;
  logic       neo_data;
  logic       ready_to_load;
  logic       ready_to_send;

  int n_cmp = 0;
  int n_fail = 0;
  int hi [NBITS];

  task_2 dut (
    .clock        (clock),
    .reset        (reset),
    .pixel_index  (pixel_index),
    .color_index  (color_index),
    .color_level  (color_level),
    .load_color   (load_color),
    .send_it      (send_it),
    .neo_data     (neo_data),
    .ready_to_load(ready_to_load),
    .ready_to_send(ready_to_send)
  );

  always #10 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: colour store plus a frame timer counting cycles since the accepted send.
  logic [7:0] m_regs  [15];
  logic [7:0] m_frame [15];
  bit         m_busy;
  int         m_t;

  initial begin
    int idx;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_frame = m_regs;
    m_busy  = 1'b0;
    m_t     = 0;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        foreach (m_regs[i]) m_regs[i] = '0;
        m_busy = 1'b0;
        m_t    = 0;
      end else if (!m_busy) begin
        idx = int'(pixel_index) * 3 + int'(color_index);
        if (load_color && int'(pixel_index) < 5 && color_index != 2'd3) m_regs[idx] = color_level;
        if (send_it) begin
          m_frame = m_regs;
          m_busy  = 1'b1;
          m_t     = 0;
        end
      end else begin
        m_t++;
        if (m_t == FRAME_C) m_busy = 1'b0;
      end
    end
  end

  initial begin
    int b;
    int ph;
    logic [7:0] byt;
    logic e_data;
    logic e_rdy;
    forever begin
      @(negedge clock);
      if (reset) begin
        e_data = 1'b0;
        e_rdy  = !m_busy;
        if (m_busy && m_t < SEND_C) begin
          b   = m_t / BIT_C;
          ph  = m_t % BIT_C;
          byt = m_frame[b / 8];
          e_data = (ph < (byt[7 - (b % 8)] ? T1 : T0));
        end
        chk("model_neo_data", int'(neo_data), int'(e_data));
        chk("model_ready_to_load", int'(ready_to_load), int'(e_rdy));
        chk("model_ready_to_send", int'(ready_to_send), int'(e_rdy));
      end
    end
  end

  task automatic do_load(input logic [2:0] p, input logic [1:0] c, input logic [7:0] lv);
    @(negedge clock);
    load_color = 1'b1; pixel_index = p; color_index = c; color_level = lv;
    @(negedge clock);
    load_color = 1'b0;
  endtask

  // Send (optionally with a simultaneous load) and record high cycles of every bit slot.
  task automatic run_frame(input bit ld, input logic [2:0] p, input logic [1:0] c,
                           input logic [7:0] lv, input bit inject);
    @(negedge clock);
    load_color = ld; pixel_index = p; color_index = c; color_level = lv; send_it = 1'b1;
    @(negedge clock);
    load_color = 1'b0; send_it = 1'b0;
    foreach (hi[i]) hi[i] = 0;
    for (int t = 0; t <= FRAME_C; t++) begin
      if (t < SEND_C) hi[t / BIT_C] += int'(neo_data);
      if (t == 0) chk("first_cycle_high", int'(neo_data), 1);
      if (t == 0) chk("ready_low_in_send", int'(ready_to_send), 0);
      if (t == SEND_C) chk("low_in_latch", int'(neo_data), 0);
      if (t == FRAME_C - 1) chk("ready_low_last_latch", int'(ready_to_send), 0);
      if (t == FRAME_C) chk("ready_back_high", int'(ready_to_load), 1);
      if (inject && t == 1000) begin
        load_color = 1'b1; pixel_index = 3'd1; color_index = 2'd1; color_level = 8'hAA;
        send_it = 1'b1;
      end
      if (inject && t == 1001) begin
        load_color = 1'b0; send_it = 1'b0;
      end
      if (t < FRAME_C) @(negedge clock);
    end
  endtask

  function automatic int n_long();
    int n = 0;
    foreach (hi[i]) if (hi[i] == T1) n++;
    return n;
  endfunction

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    chk("reset_ready_load", int'(ready_to_load), 1);
    chk("reset_ready_send", int'(ready_to_send), 1);
    chk("reset_neo_data", int'(neo_data), 0);
    repeat (100) @(negedge clock);

    // Invalid loads must not land anywhere.
    do_load(3'd6, 2'd0, 8'hFF);
    do_load(3'd0, 2'd3, 8'hFF);
    run_frame(1'b1, 3'd7, 2'd1, 8'hFF, 1'b0);
    chk("invalid_no_one_bits", n_long(), 0);
    chk("invalid_bit0_short", hi[0], T0);

    // Pixel 0 green = FF: only the first byte uses long pulses.
    do_load(3'd0, 2'd0, 8'hFF);
    run_frame(1'b0, 3'd0, 2'd0, 8'h00, 1'b0);
    chk("ff_bit0", hi[0], T1);
    chk("ff_bit7", hi[7], T1);
    chk("ff_bit8", hi[8], T0);
    chk("ff_bit119", hi[119], T0);
    chk("ff_long_count", n_long(), 8);

    // Load and send during SEND are ignored; the next frame is unchanged.
    run_frame(1'b0, 3'd0, 2'd0, 8'h00, 1'b1);
    chk("inject_long_count", n_long(), 8);
    run_frame(1'b0, 3'd0, 2'd0, 8'h00, 1'b0);
    chk("inject_p1r_bit32", hi[32], T0);
    chk("inject_p1r_bit33", hi[33], T0);
    chk("repeat_long_count", n_long(), 8);

    // Load and send on the same edge: pixel 4 blue = 01 ends the frame with a 1 bit.
    run_frame(1'b1, 3'd4, 2'd2, 8'h01, 1'b0);
    chk("same_edge_bit119", hi[119], T1);
    chk("same_edge_bit118", hi[118], T0);
    chk("same_edge_long_count", n_long(), 9);

    // Asynchronous reset mid-frame, during a high phase (start of bit 48).
    @(negedge clock);
    send_it = 1'b1;
    @(negedge clock);
    send_it = 1'b0;
    repeat (3024) @(negedge clock);
    chk("pre_reset_high", int'(neo_data), 1);
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset_data_low", int'(neo_data), 0);
    chk("async_reset_ready", int'(ready_to_send), 1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    chk("post_reset_ready", int'(ready_to_load), 1);
    run_frame(1'b0, 3'd0, 2'd0, 8'h00, 1'b0);
    chk("post_reset_regs_clear", n_long(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
